// File: rtl/ifu_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage and its consumers.
package ifu_fetch_pkg;

   localparam int IFU_XLEN      = 32;
   localparam int IFU_INSTR_LEN = 32;
   localparam int IFU_FQ_DEPTH  = 4;

   localparam logic [IFU_XLEN-1:0] IFU_RESET_VECTOR = 32'h0000_0000;

   // One fetch queue entry as seen by idu0: the instruction and the PC it came from.
   typedef struct packed {
      logic [IFU_INSTR_LEN-1:0] instr;
      logic [IFU_XLEN-1:0]      tag;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// Small synchronous FIFO with push, pop and clear, used for both the
// request tag FIFO and the instruction queue. head reads as zero when empty.
module ifu_fetch_queue #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       clear,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [WIDTH-1:0]           head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_MAX);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign head = empty ? '0 : mem[rd_ptr];

   // Entry storage; contents are only meaningful between rd_ptr and wr_ptr, so no reset.
   always_ff @(posedge clk) begin
      if (do_push & ~clear) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: issues in-order word requests to imem under a
// credit limit, queues returning instructions for idu0, and discards
// responses that were already in flight when a flush redirected the PC.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter int              XLEN         = IFU_XLEN,
   parameter int              INSTR_LEN    = IFU_INSTR_LEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = IFU_RESET_VECTOR,
   parameter int              FQ_DEPTH     = IFU_FQ_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 imem_req_valid,
   input  logic                 imem_req_ready,
   output logic [XLEN-1:0]      imem_req_addr,
   input  logic                 imem_rsp_valid,
   input  logic [INSTR_LEN-1:0] imem_rsp_data,
   input  logic                 pipe_stall,
   input  logic                 pipe_flush,
   input  logic [XLEN-1:0]      flush_pc,
   output logic [INSTR_LEN-1:0] instr,
   output logic                 instr_valid,
   output logic [XLEN-1:0]      instr_tag
);

   localparam int CW = $clog2(FQ_DEPTH+1);
   localparam int EW = INSTR_LEN + XLEN;

   localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
   localparam logic [CW-1:0]   CNT_DEPTH  = CW'(FQ_DEPTH);
   localparam logic [CW:0]     CREDIT_MAX = (CW+1)'(FQ_DEPTH);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   inflight_next;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   q_count;
   logic [CW-1:0]   tagq_count;
   logic [XLEN-1:0] tag_head;
   logic [EW-1:0]   q_head;
   logic            credit_ok;
   logic            req_fire;
   logic            rsp_drop;
   logic            q_push;
   logic            q_pop;

   // A request may only go out if its response is guaranteed a queue slot,
   // which is what lets imem return responses without backpressure.
   assign credit_ok      = ({1'b0, q_count} + {1'b0, inflight}) < CREDIT_MAX;
   assign imem_req_valid = ~rst & ~pipe_flush & credit_ok;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // Responses owed to a flushed PC stream are dropped while drop_cnt is nonzero.
   assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
   assign q_push   = imem_rsp_valid & (drop_cnt == '0) & ~pipe_flush;
   assign q_pop    = instr_valid & ~pipe_stall & ~pipe_flush;

   assign instr_valid = (q_count != '0);
   assign instr       = q_head[EW-1:XLEN];
   assign instr_tag   = q_head[XLEN-1:0];

   // Outstanding request count after this cycle's accept and response.
   always_comb begin
      inflight_next = inflight;
      if (req_fire & ~imem_rsp_valid) begin
         inflight_next = inflight + CNT_ONE;
      end else if (~req_fire & imem_rsp_valid) begin
         inflight_next = inflight - CNT_ONE;
      end
   end

   // Fetch PC, outstanding count and drop count; a flush redirects the PC and
   // marks every request still outstanding after this cycle as stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_VECTOR;
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         inflight <= inflight_next;
         if (pipe_flush) begin
            fetch_pc <= {flush_pc[XLEN-1:2], 2'b00};
            drop_cnt <= inflight_next;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + PC_STEP;
            end
            if (rsp_drop) begin
               drop_cnt <= drop_cnt - CNT_ONE;
            end
         end
      end
   end

   // Addresses of accepted requests, popped as responses come back in order;
   // never cleared, because stale responses still need their tag retired.
   ifu_fetch_queue #(
      .WIDTH (XLEN),
      .DEPTH (FQ_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_fire),
      .push_data (fetch_pc),
      .pop       (imem_rsp_valid),
      .clear     (1'b0),
      .count     (tagq_count),
      .head      (tag_head)
   );

   // Instruction queue presented to idu0, emptied on flush.
   ifu_fetch_queue #(
      .WIDTH (EW),
      .DEPTH (FQ_DEPTH)
   ) u_instr_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (q_push),
      .push_data ({imem_rsp_data, tag_head}),
      .pop       (q_pop),
      .clear     (pipe_flush),
      .count     (q_count),
      .head      (q_head)
   );

   // Credit and ordering invariants of the fetch stage.
   a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
      inflight <= CNT_DEPTH);
   a_rsp_needs_req: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (inflight != '0));
   a_drop_bound: assert property (@(posedge clk) disable iff (rst)
      drop_cnt <= inflight);
   a_tag_tracks_inflight: assert property (@(posedge clk) disable iff (rst)
      tagq_count == inflight);

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: an in-order imem with configurable latency, a
// queue-based reference of the fetch stage, directed scenarios and a
// randomized run.
module tb_ifu_fetch;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        pipe_stall;
   logic        pipe_flush;
   logic [31:0] flush_pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] instr_tag;

   ifu_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .pipe_stall     (pipe_stall),
      .pipe_flush     (pipe_flush),
      .flush_pc       (flush_pc),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .instr_tag      (instr_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 0;

   // Reference state: queued instructions, outstanding requests with a stale flag, PC.
   typedef struct {logic [31:0] instr; logic [31:0] tag;} ent_t;
   typedef struct {logic [31:0] addr; bit stale;} out_t;
   ent_t        m_fq[$];
   out_t        m_out[$];
   logic [31:0] m_pc;

   // imem model: accepted requests waiting to be answered.
   typedef struct {logic [31:0] data; int due;} pend_t;
   pend_t pending[$];
   int    lat_lo = 1;
   int    lat_hi = 1;
   bit    fixed_data = 0;

   bit          bus_acc;
   logic [31:0] bus_addr;
   logic [31:0] acc_log[$];
   logic [31:0] pop_tag_log[$];
   logic [31:0] pop_instr_log[$];
   int          first_acc = -1;
   int          first_iv  = -1;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got %08h, expected %08h", name, cyc, got, exp);
      end
   endtask

   function automatic bit exp_req_valid();
      return !rst && !pipe_flush && ((m_fq.size() + m_out.size()) < DEPTH);
   endfunction

   task automatic model_reset();
      m_pc = 32'h0;
      m_fq.delete();
      m_out.delete();
   endtask

   // Advance the reference by one clock using the inputs held during the cycle.
   task automatic model_update();
      bit   acc;
      out_t o;
      if (rst) begin
         model_reset();
         return;
      end
      acc = exp_req_valid() && imem_req_ready;
      if (m_fq.size() != 0 && !pipe_stall && !pipe_flush) void'(m_fq.pop_front());
      if (imem_rsp_valid) begin
         if (m_out.size() == 0) begin
            checkOutput("rsp_has_request", 32'd0, 32'd1);
         end else begin
            o = m_out.pop_front();
            if (!o.stale && !pipe_flush) m_fq.push_back('{imem_rsp_data, o.addr});
         end
      end
      if (acc) begin
         m_out.push_back('{m_pc, 1'b0});
         m_pc = m_pc + 32'd4;
      end
      if (pipe_flush) begin
         m_fq.delete();
         foreach (m_out[i]) m_out[i].stale = 1'b1;
         m_pc = {flush_pc[31:2], 2'b00};
      end
   endtask

   task automatic env_drive();
      if (!rst && pending.size() != 0 && pending[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = pending[0].data;
         void'(pending.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   endtask

   task automatic env_update();
      pend_t p;
      int    lat;
      if (rst) begin
         pending.delete();
      end else if (bus_acc) begin
         lat    = int'($urandom_range(lat_hi, lat_lo));
         p.data = fixed_data ? 32'h0000_0013 : $urandom;
         p.due  = cyc + lat - 1;
         pending.push_back(p);
      end
   endtask

   // One clock: drive inputs, observe the bus mid-cycle, then advance models.
   task automatic applyStimulus(input bit r, input bit s, input bit f, input logic [31:0] fpc);
      imem_req_ready = r;
      pipe_stall     = s;
      pipe_flush     = f;
      flush_pc       = fpc;
      env_drive();
      @(negedge clk);
      bus_acc  = imem_req_valid && imem_req_ready;
      bus_addr = imem_req_addr;
      if (bus_acc) begin
         acc_log.push_back(bus_addr);
         if (first_acc < 0) first_acc = cyc;
      end
      if (instr_valid) begin
         if (first_iv < 0) first_iv = cyc;
         if (!pipe_stall && !pipe_flush) begin
            pop_tag_log.push_back(instr_tag);
            pop_instr_log.push_back(instr);
         end
      end
      @(posedge clk);
      cyc++;
      model_update();
      env_update();
      #1;
   endtask

   task automatic clear_logs();
      acc_log.delete();
      pop_tag_log.delete();
      pop_instr_log.delete();
      first_acc = -1;
      first_iv  = -1;
   endtask

   task automatic drain();
      int n = 0;
      while ((pending.size() != 0 || m_out.size() != 0 || m_fq.size() != 0) && n < 50) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
         n++;
      end
      checkOutput("drain_bound", 32'(n < 50), 32'd1);
   endtask

   function automatic logic [31:0] log_at(input logic [31:0] q[$], input int idx);
      return (q.size() > idx) ? q[idx] : 32'hDEAD_BEEF;
   endfunction

   // Every cycle, all DUT outputs against the reference.
   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_req_valid()));
         checkOutput("req_addr", imem_req_addr, m_pc);
         checkOutput("instr_valid", 32'(instr_valid), 32'(m_fq.size() != 0));
         checkOutput("instr", instr, (m_fq.size() != 0) ? m_fq[0].instr : 32'h0);
         checkOutput("instr_tag", instr_tag, (m_fq.size() != 0) ? m_fq[0].tag : 32'h0);
      end
   end

   initial begin
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      pipe_stall     = 1'b0;
      pipe_flush     = 1'b0;
      flush_pc       = 32'h0;
      model_reset();
      #2;
      checkOutput("reset_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("reset_req_addr", imem_req_addr, 32'h0);
      checkOutput("reset_instr_valid", 32'(instr_valid), 32'd0);
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

      // Reset release with always-ready, single-cycle imem returning NOPs.
      $display("[TB] reset release sequence");
      rst = 1'b0;
      fixed_data = 1'b1;
      clear_logs();
      repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("first_valid_latency", 32'(first_iv - first_acc), 32'd2);
      checkOutput("first_addr0", log_at(acc_log, 0), 32'h0);
      checkOutput("first_addr1", log_at(acc_log, 1), 32'h4);
      checkOutput("first_tag0", log_at(pop_tag_log, 0), 32'h0);
      checkOutput("first_tag1", log_at(pop_tag_log, 1), 32'h4);
      checkOutput("first_tag2", log_at(pop_tag_log, 2), 32'h8);
      checkOutput("first_instr", log_at(pop_instr_log, 0), 32'h0000_0013);
      fixed_data = 1'b0;

      // Credit limit under stall, then release.
      $display("[TB] credit limit");
      drain();
      clear_logs();
      repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("credit_accepts", 32'(acc_log.size()), 32'd4);
      checkOutput("credit_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("credit_instr_valid", 32'(instr_valid), 32'd1);
      pop_tag_log.delete();
      repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("release_pops", 32'(pop_tag_log.size()), 32'd6);
      checkOutput("release_accepts", 32'(acc_log.size()), 32'd9);

      // Flush with three requests in flight at 3-cycle latency.
      $display("[TB] flush with requests in flight");
      drain();
      clear_logs();
      lat_lo = 3;
      lat_hi = 3;
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
      checkOutput("flush_q_empty", 32'(instr_valid), 32'd0);
      lat_lo = 1;
      lat_hi = 1;
      pop_tag_log.delete();
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("flush_first_addr", log_at(acc_log, 3), 32'h100);
      checkOutput("flush_first_tag", log_at(pop_tag_log, 0), 32'h100);

      // Misaligned redirect and PC wrap.
      $display("[TB] misaligned redirect and wrap");
      drain();
      clear_logs();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h203);
      checkOutput("misaligned_addr", imem_req_addr, 32'h200);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("misaligned_accept", log_at(acc_log, 0), 32'h200);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      clear_logs();
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("wrap_addr0", log_at(acc_log, 0), 32'hFFFF_FFFC);
      checkOutput("wrap_addr1", log_at(acc_log, 1), 32'h0);

      // Stall and flush together with a non-empty queue.
      $display("[TB] stall with flush");
      drain();
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h300);
      checkOutput("stall_flush_empty", 32'(instr_valid), 32'd0);
      clear_logs();
      repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_flush_tag", log_at(pop_tag_log, 0), 32'h300);

      // Randomized traffic.
      $display("[TB] random traffic");
      lat_lo = 1;
      lat_hi = 4;
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                       $urandom_range(0, 99) < 5, $urandom);
      end

      // Asynchronous reset with two requests outstanding.
      $display("[TB] mid-operation reset");
      drain();
      lat_lo = 3;
      lat_hi = 3;
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      #2;
      rst = 1'b1;
      model_reset();
      pending.delete();
      #1;
      checkOutput("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("async_rst_instr_valid", 32'(instr_valid), 32'd0);
      checkOutput("async_rst_instr", instr, 32'h0);
      checkOutput("async_rst_tag", instr_tag, 32'h0);
      checkOutput("async_rst_addr", imem_req_addr, 32'h0);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
      lat_lo = 1;
      lat_hi = 1;
      clear_logs();
      repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("post_rst_addr", log_at(acc_log, 0), 32'h0);
      drain();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage sitting directly upstream of idu0.
- Holds the fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel.
- Buffers returning instructions in a small fetch queue and presents the queue head to idu0 as instr / instr_valid / instr_tag.
- Handles pipeline stall and flush/redirect, discarding stale in-flight responses with a drop counter.

Parameters:
- XLEN, 32, address / tag width.
- INSTR_LEN, 32, instruction width.
- RESET_VECTOR, 32'h0000_0000, first fetch PC after reset.
- FQ_DEPTH, 4, fetch queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  imem accepts request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses are in order, at least 1 cycle after acceptance, with no backpressure.
- imem_rsp_data  in  INSTR_LEN  fetched instruction.
- pipe_stall  in  1  idu0 not consuming.
- pipe_flush  in  1  flush and redirect.
- flush_pc  in  XLEN  redirect target, valid with pipe_flush.
- instr  out  INSTR_LEN  queue head instruction to idu0.
- instr_valid  out  1  queue non-empty.
- instr_tag  out  XLEN  PC of the queue head.

Behaviour:
- **Reset (rst high, async).**
  - fetch_pc = RESET_VECTOR; queue empty.
  - inflight = 0; drop_cnt = 0.
  - Outputs: imem_req_valid=0, instr_valid=0, instr=0, instr_tag=0, imem_req_addr=RESET_VECTOR.
- **Request issue.**
  - imem_req_valid = ~pipe_flush & (q_count + inflight < FQ_DEPTH).
  - imem_req_addr = fetch_pc.
  - The credit rule guarantees every response has a queue slot, so there is no response backpressure.
  - Accept = valid & ready. On accept: fetch_pc += 4 (wraps 0xFFFF_FFFC -> 0), inflight++, and the address is pushed to a tag FIFO alongside the request.
- **Valid stickiness.** imem_req_valid is combinational and may drop without acceptance (on flush or credit loss); imem must tolerate withdrawn requests.
- **Response handling.**
  - A response with drop_cnt==0: push {data, tag-FIFO head} into the queue; inflight--.
  - A response with drop_cnt>0: discard the data, pop the tag, drop_cnt--, inflight--.
  - Accept and response in the same cycle: inflight is unchanged.
- **Output.**
  - instr_valid = q_count != 0.
  - instr / instr_tag come from the queue head, or 0 when the queue is empty.
  - Pop when instr_valid & ~pipe_stall & ~pipe_flush.
  - Push and pop in the same cycle are allowed; a full queue with a simultaneous pop and push is legal.
- **Flush (pipe_flush high, one cycle).**
  - fetch_pc <= {flush_pc[XLEN-1:2], 2'b00}; queue cleared.
  - drop_cnt <= inflight_next, i.e. all requests still outstanding after this cycle's response/accept; a response arriving in the flush cycle is discarded.
  - No request is issued in the flush cycle; fetch from flush_pc begins the next cycle.
  - Flush has priority over stall, push and pop.
  - Consecutive flushes: the last one wins, and drop_cnt is recomputed each time.
- **Stall.** Freezes the queue head; fetch continues until credits are exhausted.
- **Latency.** Accept at cycle N, response at N+k; instr_valid no earlier than N+k+1 (registered queue).
- **Counter widths.** inflight, drop_cnt and q_count are each $clog2(FQ_DEPTH+1) bits.
- **Assertions.** inflight never exceeds FQ_DEPTH; no response while inflight==0; drop_cnt <= inflight.

Decomposition:
- XLEN, INSTR_LEN and RESET_VECTOR default go in the shared global constants header.
- A fetch_entry_t typedef {instr, tag} goes in the shared types package.
- One sub-module: ifu_fetch_queue, a synchronous FIFO parameterised by width/depth with push, pop, clear, count, head; instantiated twice (tag FIFO and instruction queue).

Test Plan:
- **Reset.** Release rst, imem always ready, 1-cycle responses data=0x00000013 -> addresses 0x0, 0x4, 0x8...; instr_valid first high 2 cycles after first accept; instr_tag sequence 0x0, 0x4, 0x8.
- **Credit limit.** pipe_stall=1 with FQ_DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0; release stall -> one pop per cycle and fetch resumes.
- **Flush with in-flight requests.** 3 requests in flight, 3-cycle latency; pipe_flush with flush_pc=0x100 -> 3 responses discarded, next instr_tag=0x100, queue empty the cycle after the flush.
- **Misaligned redirect and wrap.** flush_pc=0x203 -> first imem_req_addr=0x200; separately flush_pc=0xFFFFFFFC -> next addresses 0xFFFFFFFC, 0x0.
- **Simultaneous events.** A response in the flush cycle is dropped; pipe_stall and pipe_flush together -> flush wins; a full queue with pop and push in the same cycle -> q_count stays FQ_DEPTH.
- **Mid-operation reset.** Assert rst asynchronously with 2 requests in flight -> all outputs at reset values immediately; late responses after reset must be blocked by the bench's imem reset, and the inflight==0 assertion must hold.
